// File: rtl/e_scan_dispatch.sv
// SCAN (collective) elevator dispatcher: latches floor requests and sweeps in one
// direction while requests remain ahead, stopping with the door open at requested floors.
module e_scan_dispatch #(
    parameter int NUM_FLR  = 4,
    parameter int DOOR_CYC = 8,
    parameter int TMR_W    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_FLR-1:0] bts,
    input  logic [NUM_FLR-1:0] curFlr,
    input  logic               atFlr,
    output logic [NUM_FLR-1:0] pending,
    output logic [NUM_FLR-1:0] target,
    output logic               dir,
    output logic               move,
    output logic               doorOpen
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2,
        DOOR = 2'd3
    } state_t;

    localparam logic [NUM_FLR-1:0] FLR_ONE   = NUM_FLR'(1);
    localparam logic [TMR_W-1:0]   TMR_ONE   = TMR_W'(1);
    localparam logic [TMR_W-1:0]   DOOR_LOAD = TMR_W'(DOOR_CYC);

    state_t             state_q, state_d;
    logic [NUM_FLR-1:0] pending_q, pending_d;
    logic [NUM_FLR-1:0] target_q, target_d;
    logic               dir_q, dir_d;
    logic               move_q, move_d;
    logic               doorOpen_q, doorOpen_d;
    logic [TMR_W-1:0]   timer_q, timer_d;

    logic [NUM_FLR-1:0] shiftedFlr;
    logic [NUM_FLR-1:0] aboveMask;
    logic [NUM_FLR-1:0] belowMask;
    logic [NUM_FLR-1:0] clr;
    logic [NUM_FLR-1:0] upCand;
    logic [NUM_FLR-1:0] downCand;
    logic               flrValid;
    logic               here;
    logic               above;
    logic               below;
    logic               ahead;
    logic               behind;
    logic               doEval;
    logic               enterDoor;

    function automatic logic [NUM_FLR-1:0] lowestBit(input logic [NUM_FLR-1:0] v);
        logic [NUM_FLR-1:0] r;
        r = '0;
        for (int i = NUM_FLR - 1; i >= 0; i--) begin
            if (v[i]) begin
                r    = '0;
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic logic [NUM_FLR-1:0] highestBit(input logic [NUM_FLR-1:0] v);
        logic [NUM_FLR-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_FLR; i++) begin
            if (v[i]) begin
                r    = '0;
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

    // Floors strictly above/below a one-hot position; shifting past the top floor yields an empty above-mask.
    assign shiftedFlr = curFlr << 1;
    assign aboveMask  = ~(shiftedFlr - FLR_ONE);
    assign belowMask  = curFlr - FLR_ONE;
    assign flrValid   = (curFlr != '0) && ((curFlr & (curFlr - FLR_ONE)) == '0);

    assign here   = |(pending_q & curFlr);
    assign above  = |(pending_q & aboveMask);
    assign below  = |(pending_q & belowMask);
    assign ahead  = dir_q ? above : below;
    assign behind = dir_q ? below : above;

    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        timer_d    = timer_q;
        target_d   = target_q;
        clr        = '0;
        doEval     = 1'b0;
        enterDoor  = 1'b0;
        upCand     = '0;
        downCand   = '0;

        if (flrValid) begin
            unique case (state_q)
                IDLE: doEval = 1'b1;
                UP: begin
                    if (atFlr) begin
                        if (here) begin
                            enterDoor = 1'b1;
                        end else if (!above) begin
                            state_d = IDLE;
                        end
                    end
                end
                DOWN: begin
                    if (atFlr) begin
                        if (here) begin
                            enterDoor = 1'b1;
                        end else if (!below) begin
                            state_d = IDLE;
                        end
                    end
                end
                DOOR: begin
                    // A press on the floor being served keeps the door open instead of latching.
                    if (|(bts & curFlr)) begin
                        clr     = curFlr;
                        timer_d = DOOR_LOAD;
                    end else if (timer_q <= TMR_ONE) begin
                        timer_d = '0;
                        doEval  = 1'b1;
                    end else begin
                        timer_d = timer_q - TMR_ONE;
                    end
                end
                default: state_d = IDLE;
            endcase

            if (doEval) begin
                if (here) begin
                    enterDoor = 1'b1;
                end else if (ahead) begin
                    state_d = dir_q ? UP : DOWN;
                end else if (behind) begin
                    dir_d   = ~dir_q;
                    state_d = dir_q ? DOWN : UP;
                end else begin
                    state_d = IDLE;
                end
            end

            if (enterDoor) begin
                state_d = DOOR;
                clr     = curFlr;
                timer_d = DOOR_LOAD;
            end
        end

        pending_d = (pending_q | bts) & ~clr;

        // Nearest request in the travel direction first, otherwise the nearest one behind.
        if (flrValid) begin
            upCand   = lowestBit(pending_d & aboveMask);
            downCand = highestBit(pending_d & belowMask);
            if (dir_d) begin
                target_d = (upCand != '0) ? upCand : downCand;
            end else begin
                target_d = (downCand != '0) ? downCand : upCand;
            end
        end

        move_d     = flrValid && ((state_d == UP) || (state_d == DOWN));
        doorOpen_d = (state_d == DOOR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pending_q  <= '0;
            target_q   <= '0;
            dir_q      <= 1'b1;
            move_q     <= 1'b0;
            doorOpen_q <= 1'b0;
            timer_q    <= '0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            target_q   <= target_d;
            dir_q      <= dir_d;
            move_q     <= move_d;
            doorOpen_q <= doorOpen_d;
            timer_q    <= timer_d;
        end
    end

    assign pending  = pending_q;
    assign target   = target_q;
    assign dir      = dir_q;
    assign move     = move_q;
    assign doorOpen = doorOpen_q;

endmodule

// File: tb/tb_e_scan_dispatch.sv
// Directed self-checking bench for e_scan_dispatch with four floors and a three-cycle door.
module tb_e_scan_dispatch;

    logic       clk;
    logic       rst;
    logic [3:0] bts;
    logic [3:0] curFlr;
    logic       atFlr;
    logic [3:0] pending;
    logic [3:0] target;
    logic       dir;
    logic       move;
    logic       doorOpen;

    int compared;
    int mismatched;

    e_scan_dispatch #(
        .NUM_FLR (4),
        .DOOR_CYC(3),
        .TMR_W   (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bts     (bts),
        .curFlr  (curFlr),
        .atFlr   (atFlr),
        .pending (pending),
        .target  (target),
        .dir     (dir),
        .move    (move),
        .doorOpen(doorOpen)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic r, input logic [3:0] b, input logic [3:0] c,
                                 input logic a);
        rst    = r;
        bts    = b;
        curFlr = c;
        atFlr  = a;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkAll(input string tag, input logic [3:0] ePend, input logic [3:0] eTgt,
                            input logic eDir, input logic eMove, input logic eDoor);
        checkOutput({tag, ".pending"}, 32'(pending), 32'(ePend));
        checkOutput({tag, ".target"}, 32'(target), 32'(eTgt));
        checkOutput({tag, ".dir"}, 32'(dir), 32'(eDir));
        checkOutput({tag, ".move"}, 32'(move), 32'(eMove));
        checkOutput({tag, ".doorOpen"}, 32'(doorOpen), 32'(eDoor));
    endtask

    initial begin
        clk        = 1'b0;
        compared   = 0;
        mismatched = 0;

        // Reset values
        applyStimulus(1'b1, 4'b0000, 4'b0001, 1'b1);
        applyStimulus(1'b1, 4'b0000, 4'b0001, 1'b1);
        checkAll("reset", 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);

        // Single trip 0 -> 2 with a three-cycle door
        applyStimulus(1'b0, 4'b0100, 4'b0001, 1'b1);
        checkAll("t1.latch", 4'b0100, 4'b0100, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'b0000, 4'b0001, 1'b0);
        checkAll("t1.depart", 4'b0100, 4'b0100, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'b0000, 4'b0100, 1'b1);
        checkAll("t1.arrive", 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 4'b0000, 4'b0100, 1'b1);
        checkAll("t1.door2", 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 4'b0000, 4'b0100, 1'b1);
        checkAll("t1.door3", 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 4'b0000, 4'b0100, 1'b1);
        checkAll("t1.closed", 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'b0000, 4'b0100, 1'b1);
        checkAll("t1.idle", 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);

        // Collective stops at 1 then 3 while travelling up
        applyStimulus(1'b1, 4'b0000, 4'b0001, 1'b1);
        applyStimulus(1'b0, 4'b1010, 4'b0001, 1'b1);
        checkAll("t2.latch", 4'b1010, 4'b0010, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'b0000, 4'b0001, 1'b0);
        checkAll("t2.depart", 4'b1010, 4'b0010, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'b0000, 4'b0010, 1'b1);
        checkAll("t2.stop1", 4'b1000, 4'b1000, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 4'b0000, 4'b0010, 1'b1);
        applyStimulus(1'b0, 4'b0000, 4'b0010, 1'b1);
        checkAll("t2.door3", 4'b1000, 4'b1000, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 4'b0000, 4'b0010, 1'b1);
        checkAll("t2.resume", 4'b1000, 4'b1000, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'b0000, 4'b0100, 1'b1);
        checkAll("t2.pass2", 4'b1000, 4'b1000, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'b0000, 4'b1000, 1'b1);
        checkAll("t2.stop3", 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 4'b0000, 4'b1000, 1'b1);
        applyStimulus(1'b0, 4'b0000, 4'b1000, 1'b1);
        applyStimulus(1'b0, 4'b0000, 4'b1000, 1'b1);
        checkAll("t2.closed", 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);

        // Upper request served before reversing to a lower one
        applyStimulus(1'b1, 4'b0000, 4'b0001, 1'b1);
        applyStimulus(1'b0, 4'b1000, 4'b0001, 1'b1);
        checkAll("t3.latch", 4'b1000, 4'b1000, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'b0000, 4'b0001, 1'b0);
        checkAll("t3.depart", 4'b1000, 4'b1000, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'b0001, 4'b0010, 1'b0);
        checkAll("t3.lowreq", 4'b1001, 4'b1000, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'b0000, 4'b0100, 1'b0);
        checkAll("t3.pass2", 4'b1001, 4'b1000, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'b0000, 4'b1000, 1'b1);
        checkAll("t3.stop3", 4'b0001, 4'b0001, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 4'b0000, 4'b1000, 1'b1);
        applyStimulus(1'b0, 4'b0000, 4'b1000, 1'b1);
        checkAll("t3.door3", 4'b0001, 4'b0001, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 4'b0000, 4'b1000, 1'b1);
        checkAll("t3.reverse", 4'b0001, 4'b0001, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'b0000, 4'b0001, 1'b1);
        checkAll("t3.stop0", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1);

        // Re-press on the served floor reloads the door timer
        applyStimulus(1'b1, 4'b0000, 4'b0001, 1'b1);
        applyStimulus(1'b0, 4'b0100, 4'b0001, 1'b0);
        applyStimulus(1'b0, 4'b0000, 4'b0001, 1'b0);
        applyStimulus(1'b0, 4'b0000, 4'b0100, 1'b1);
        checkAll("t4.open", 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 4'b0000, 4'b0100, 1'b1);
        applyStimulus(1'b0, 4'b0000, 4'b0100, 1'b1);
        applyStimulus(1'b0, 4'b0100, 4'b0100, 1'b1);
        checkAll("t4.reload", 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 4'b0000, 4'b0100, 1'b1);
        checkAll("t4.hold1", 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 4'b0000, 4'b0100, 1'b1);
        checkAll("t4.hold2", 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 4'b0000, 4'b0100, 1'b1);
        checkAll("t4.closed", 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);

        // Invalid floor feedback halts the motor but keeps latching requests
        applyStimulus(1'b1, 4'b0000, 4'b0001, 1'b1);
        applyStimulus(1'b0, 4'b0100, 4'b0001, 1'b0);
        applyStimulus(1'b0, 4'b0000, 4'b0001, 1'b0);
        checkAll("t5.moving", 4'b0100, 4'b0100, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'b0000, 4'b0110, 1'b0);
        checkAll("t5.invalid", 4'b0100, 4'b0100, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'b0010, 4'b0110, 1'b1);
        checkAll("t5.latch", 4'b0110, 4'b0100, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'b0000, 4'b0100, 1'b0);
        checkAll("t5.resume", 4'b0110, 4'b0010, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'b0000, 4'b0100, 1'b1);
        checkAll("t5.stop", 4'b0010, 4'b0010, 1'b1, 1'b0, 1'b1);

        // Reset during the door phase drops requests and ignores a same-cycle press
        applyStimulus(1'b1, 4'b0000, 4'b0001, 1'b1);
        applyStimulus(1'b0, 4'b0100, 4'b0001, 1'b0);
        applyStimulus(1'b0, 4'b0000, 4'b0001, 1'b0);
        applyStimulus(1'b0, 4'b0000, 4'b0100, 1'b1);
        applyStimulus(1'b0, 4'b1001, 4'b0100, 1'b1);
        checkAll("t6.door", 4'b1001, 4'b1000, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 4'b0010, 4'b0100, 1'b1);
        checkAll("t6.reset", 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'b0000, 4'b0100, 1'b1);
        checkAll("t6.after1", 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'b0000, 4'b0100, 1'b1);
        checkAll("t6.after2", 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
